uart_rx_sampler: RTL and testbench
==================================

// Module: uart_rx_sampler
// PURPOSE
//  Standalone UART receiver: the far end of the serial TxD line produced by the uart transmitter.
//  Samples the asynchronous RxD line at OVERSAMPLE x baud in the rck domain.
//  Validates the start bit and majority-votes each bit.
//  Deserialises 8N1 frames LSB-first; flags good bytes and framing errors.
//  Loopback partner for uart TxD in block and system benches.
// PARAMETERS
//  CLK_FREQ    6_250_000  rck frequency in Hz
//  BAUD_RATE   9_600      line rate in bit/s
//  OVERSAMPLE  16         sample ticks per bit; even, >=8
//  DATA_BITS   8          data bits per frame, 5..9
// PORTS
//  rck         in   1          receive clock; all logic on posedge
//  reset       in   1          asynchronous, active-low reset
//  RxD         in   1          serial input, asynchronous, idles high
//  RxData      out  DATA_BITS  last good byte; held until next good frame
//  RxValid     out  1          1-rck pulse: RxData updated this cycle
//  RxFrameErr  out  1          1-rck pulse: stop bit sampled low
//  RxBusy      out  1          high from start-bit detect until return to IDLE
// BEHAVIOUR
//  - Reset (reset==0, asynchronous): state=IDLE; RxData=0; RxValid=0; RxFrameErr=0; RxBusy=0;
//    synchroniser flops=1; counters=0. Reset mid-frame discards the partial byte.
//  - Sync: RxD passes through 2 flops; all decisions use the synchronised value rxs.
//  - Tick: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer-truncated, minimum 1.
//    The tick counter counts 0..DIV-1 and emits a 1-cycle tick at DIV-1.
//    The counter is held at 0 in IDLE and restarts at 0 on start detect.
//  - Sample index s counts ticks 0..OVERSAMPLE-1 within a bit and wraps to 0 at the bit end.
//    Bit value = majority of rxs at s = OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
//  - FSM:
//    IDLE:  rxs==0 -> START, RxBusy=1.
//    START: at s=OVERSAMPLE/2+1, vote==1 -> IDLE (false start, no pulses).
//           Otherwise at the bit end -> DATA, bit count=0.
//    DATA:  at the vote point, shift vote into the MSB of the shift register (LSB-first line order).
//           At the bit end, bit count++. After DATA_BITS bits -> STOP.
//    STOP:  at the vote point:
//           vote==1 -> RxData<=shift, RxValid=1 next cycle, -> IDLE (RxBusy=0).
//             Re-arms mid stop bit so back-to-back frames are caught.
//           vote==0 -> RxFrameErr=1 next cycle, RxData unchanged, -> BREAK.
//    BREAK: waits for rxs==1, then -> IDLE. A held-low line yields exactly one RxFrameErr.
//  - RxValid and RxFrameErr are never high together; each is exactly one rck wide.
//  - Latency: RxValid asserts 2 (sync) + 1 (register) rck after the stop-bit vote sample.
//  - Framing: no parity and no overrun detection; the consumer must take RxData before the next
//    RxValid.
// TESTING
//  Bench configuration: CLK_FREQ=32_000_000, BAUD_RATE=1_000_000, OVERSAMPLE=16 -> DIV=2,
//  bit period = 32 rck.
//  1. Frame 0xA5 with stop=1 -> exactly one RxValid pulse, RxData=8'hA5, RxFrameErr never high.
//  2. RxD low for 8 rck, then high -> no RxValid/RxFrameErr; RxBusy falls within 1 bit period.
//  3. Frame 0x3C with stop bit driven 0, line held low 3 bits -> one RxFrameErr pulse, no RxValid,
//     RxData stays 0xA5. A following 0x11 after the line returns high is received.
//  4. Back-to-back 0x00 then 0xFF, zero idle gap -> two RxValid pulses 320 rck apart (+-1),
//     RxData 0x00 then 0xFF.
//  5. reset pulled low during data bit 4 of 0x77 -> outputs 0 asynchronously, no pulse for 0x77.
//     The next frame 0x5A -> RxValid with RxData=8'h5A.
//  6. Frame 0x81 with sample s=7 inverted on every bit -> majority vote yields RxData=8'h81, RxValid=1.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// Oversampling 8N1 UART receiver: synchronises RxD, validates the start bit,
// majority-votes three mid-bit samples and flags good bytes or framing errors.
module uart_rx_sampler #(
  parameter int CLK_FREQ   = 6_250_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 rck,
  input  logic                 reset,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  output logic                 RxFrameErr,
  output logic                 RxBusy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_BITS);

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_V0     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2     = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;

  state_e                 state_q, state_d;
  logic                   rxMeta_q, rxs_q;
  logic [CW-1:0]          tickCnt_q, tickCnt_d;
  logic [SW-1:0]          sampIdx_q, sampIdx_d;
  logic [BW-1:0]          bitCnt_q, bitCnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rxData_q, rxData_d;
  logic                   sampA_q, sampA_d;
  logic                   sampB_q, sampB_d;
  logic                   rxValid_q, rxValid_d;
  logic                   frameErr_q, frameErr_d;
  logic                   tick, votePoint, bitEnd, vote;

  assign tick      = (state_q != IDLE) && (state_q != BREAK) && (tickCnt_q == DIV_LAST);
  assign votePoint = tick && (sampIdx_q == S_V2);
  assign bitEnd    = tick && (sampIdx_q == S_LAST);
  // The third vote sample is the live synchronised value at the vote tick.
  assign vote      = (sampA_q & sampB_q) | (sampA_q & rxs_q) | (sampB_q & rxs_q);

  always_comb begin
    state_d    = state_q;
    tickCnt_d  = tickCnt_q;
    sampIdx_d  = sampIdx_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    rxData_d   = rxData_q;
    sampA_d    = sampA_q;
    sampB_d    = sampB_q;
    rxValid_d  = 1'b0;
    frameErr_d = 1'b0;

    if (tick && (sampIdx_q == S_V0)) sampA_d = rxs_q;
    if (tick && (sampIdx_q == S_V1)) sampB_d = rxs_q;

    case (state_q)
      IDLE: begin
        if (!rxs_q) state_d = START;
      end
      START: begin
        if (votePoint && vote) begin
          state_d = IDLE;
        end else if (bitEnd) begin
          state_d  = DATA;
          bitCnt_d = '0;
        end
      end
      DATA: begin
        if (votePoint) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (bitEnd) begin
          bitCnt_d = bitCnt_q + BW'(1);
          if (bitCnt_q == BIT_LAST) state_d = STOP;
        end
      end
      STOP: begin
        // Deciding at the stop-bit vote re-arms early enough for zero-gap frames.
        if (votePoint) begin
          if (vote) begin
            rxData_d  = shift_q;
            rxValid_d = 1'b1;
            state_d   = IDLE;
          end else begin
            frameErr_d = 1'b1;
            state_d    = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == IDLE) || (state_q == BREAK) || (state_d == IDLE)) begin
      tickCnt_d = '0;
      sampIdx_d = '0;
    end else begin
      tickCnt_d = tick ? '0 : tickCnt_q + CW'(1);
      if (tick) sampIdx_d = (sampIdx_q == S_LAST) ? '0 : sampIdx_q + SW'(1);
    end
  end

  always_ff @(posedge rck or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rxMeta_q   <= 1'b1;
      rxs_q      <= 1'b1;
      tickCnt_q  <= '0;
      sampIdx_q  <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      rxData_q   <= '0;
      sampA_q    <= 1'b1;
      sampB_q    <= 1'b1;
      rxValid_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rxMeta_q   <= RxD;
      rxs_q      <= rxMeta_q;
      tickCnt_q  <= tickCnt_d;
      sampIdx_q  <= sampIdx_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      rxData_q   <= rxData_d;
      sampA_q    <= sampA_d;
      sampB_q    <= sampB_d;
      rxValid_q  <= rxValid_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign RxData     = rxData_q;
  assign RxValid    = rxValid_q;
  assign RxFrameErr = frameErr_q;
  assign RxBusy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: good frames, false start, framing error,
// back-to-back frames, mid-frame reset and glitch rejection by majority vote.
module tb_uart_rx_sampler;

  localparam int BIT_CYCLES = 32;

  logic       clock = 1'b0;
  logic       resetN;
  logic       rxD;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxFrameErr;
  logic       rxBusy;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int validCount = 0;
  int frameErrCount = 0;
  int overlapCount = 0;
  logic [7:0] validData[$];
  int validTime[$];

  always #5 clock = ~clock;

  uart_rx_sampler #(
    .CLK_FREQ(32_000_000),
    .BAUD_RATE(1_000_000),
    .OVERSAMPLE(16),
    .DATA_BITS(8)
  ) dut (
    .rck(clock),
    .reset(resetN),
    .RxD(rxD),
    .RxData(rxData),
    .RxValid(rxValid),
    .RxFrameErr(rxFrameErr),
    .RxBusy(rxBusy)
  );

  always @(posedge clock) cycle <= cycle + 1;

  // Pulse monitor samples on the falling edge, clear of the register updates.
  always @(negedge clock) begin
    if (rxValid) begin
      validCount++;
      validData.push_back(rxData);
      validTime.push_back(cycle);
    end
    if (rxFrameErr) frameErrCount++;
    if (rxValid && rxFrameErr) overlapCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveBit(input logic value, input int cycles);
    rxD = value;
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  // Glitch mode flips the line for the two cycles covering the first vote sample of each bit.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic glitch);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (glitch) begin
        driveBit(frame[i], 15);
        driveBit(~frame[i], 2);
        driveBit(frame[i], 15);
      end else begin
        driveBit(frame[i], BIT_CYCLES);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int v0, e0, n0;
    logic [7:0] partial;

    rxD    = 1'b1;
    resetN = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset RxData", rxData, 8'h00);
    checkOutput("reset RxValid", rxValid, 1'b0);
    checkOutput("reset RxFrameErr", rxFrameErr, 1'b0);
    checkOutput("reset RxBusy", rxBusy, 1'b0);
    resetN = 1'b1;
    driveBit(1'b1, 10);

    $display("[TB] frame 0xA5");
    v0 = validCount; e0 = frameErrCount;
    applyStimulus(8'hA5, 1'b1, 1'b0);
    driveBit(1'b1, 20);
    checkOutput("A5 valid count", validCount - v0, 1);
    checkOutput("A5 data", rxData, 8'hA5);
    checkOutput("A5 no frame err", frameErrCount - e0, 0);
    checkOutput("A5 busy idle", rxBusy, 1'b0);

    $display("[TB] false start");
    v0 = validCount; e0 = frameErrCount;
    driveBit(1'b0, 5);
    checkOutput("false start busy", rxBusy, 1'b1);
    driveBit(1'b0, 3);
    driveBit(1'b1, 24);
    checkOutput("false start busy drop", rxBusy, 1'b0);
    driveBit(1'b1, 40);
    checkOutput("false start no valid", validCount - v0, 0);
    checkOutput("false start no err", frameErrCount - e0, 0);

    $display("[TB] framing error then 0x11");
    v0 = validCount; e0 = frameErrCount;
    applyStimulus(8'h3C, 1'b0, 1'b0);
    driveBit(1'b0, 3 * BIT_CYCLES);
    checkOutput("break busy", rxBusy, 1'b1);
    driveBit(1'b1, 40);
    checkOutput("break one err", frameErrCount - e0, 1);
    checkOutput("break no valid", validCount - v0, 0);
    checkOutput("break data held", rxData, 8'hA5);
    checkOutput("break busy clear", rxBusy, 1'b0);
    applyStimulus(8'h11, 1'b1, 1'b0);
    driveBit(1'b1, 20);
    checkOutput("post break valid", validCount - v0, 1);
    checkOutput("post break data", rxData, 8'h11);

    $display("[TB] back-to-back 0x00 0xFF");
    v0 = validCount; e0 = frameErrCount; n0 = validData.size();
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    driveBit(1'b1, 20);
    checkOutput("b2b valid count", validCount - v0, 2);
    checkOutput("b2b no err", frameErrCount - e0, 0);
    if (validData.size() >= n0 + 2) begin
      checkOutput("b2b first data", validData[n0], 8'h00);
      checkOutput("b2b second data", validData[n0+1], 8'hFF);
      checkOutput("b2b spacing ok",
                  ((validTime[n0+1] - validTime[n0]) >= 319) && ((validTime[n0+1] - validTime[n0]) <= 321), 1'b1);
    end
    checkOutput("b2b final data", rxData, 8'hFF);

    $display("[TB] reset during 0x77");
    v0 = validCount; e0 = frameErrCount;
    partial = 8'h77;
    driveBit(1'b0, BIT_CYCLES);
    for (int i = 0; i < 4; i++) driveBit(partial[i], BIT_CYCLES);
    driveBit(partial[4], 16);
    checkOutput("pre reset busy", rxBusy, 1'b1);
    resetN = 1'b0;
    #2;
    checkOutput("mid reset RxData", rxData, 8'h00);
    checkOutput("mid reset RxBusy", rxBusy, 1'b0);
    checkOutput("mid reset RxValid", rxValid, 1'b0);
    driveBit(1'b1, 3);
    resetN = 1'b1;
    driveBit(1'b1, 320);
    checkOutput("no 77 valid", validCount - v0, 0);
    checkOutput("no 77 err", frameErrCount - e0, 0);
    applyStimulus(8'h5A, 1'b1, 1'b0);
    driveBit(1'b1, 20);
    checkOutput("5A valid", validCount - v0, 1);
    checkOutput("5A data", rxData, 8'h5A);

    $display("[TB] glitched 0x81");
    v0 = validCount; e0 = frameErrCount;
    applyStimulus(8'h81, 1'b1, 1'b1);
    driveBit(1'b1, 20);
    checkOutput("81 valid", validCount - v0, 1);
    checkOutput("81 data", rxData, 8'h81);
    checkOutput("81 no err", frameErrCount - e0, 0);

    checkOutput("valid/err overlap", overlapCount, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
